// File: rtl/sync_arith_pkg.sv
// Shared definitions for the synchronous arithmetic units: opcodes, status bit
// positions and the FSM state encoding of the inverse-operation unit.
package sync_arith_pkg;

  typedef enum logic [3:0] {
    OP_SHL  = 4'b0000,
    OP_MUL  = 4'b0001,
    OP_U2ZM = 4'b0010
  } op_e;

  localparam int ST_ZERO = 0;
  localparam int ST_NEG  = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_INV  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WB
  } state_e;

  function automatic logic [3:0] pack_status(input logic zero, input logic neg,
                                             input logic ovf, input logic inv);
    logic [3:0] s;
    s = '0;
    s[ST_ZERO] = zero;
    s[ST_NEG]  = neg;
    s[ST_OVF]  = ovf;
    s[ST_INV]  = inv;
    return s;
  endfunction

endpackage

// File: rtl/seq_mul_29.sv
// Unsigned shift-add multiplier: loads on start, then runs M iterations that
// add the multiplicand into the upper half and shift the accumulator right.
module seq_mul_29 #(
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           done,
  output logic [2*M-1:0] product
);

  localparam int CW = $clog2(M) + 1;
  localparam logic [CW-1:0] LAST = CW'(M);

  logic [2*M-1:0] acc_q, acc_d;
  logic [M-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   addend;
  logic [M:0]     sum;

  // The low half starts as the multiplier and is consumed one bit per iteration.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    addend  = acc_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q[2*M-1:M]} + {1'b0, addend};
    if (start) begin
      acc_d   = {{M{1'b0}}, b};
      mcand_d = a;
      cnt_d   = '0;
    end else if (cnt_q != LAST) begin
      acc_d = {sum, acc_q[M-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= LAST;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done    = (cnt_q == LAST);
  assign product = acc_q;

endmodule

// File: rtl/sync_arith_inv_unit_29.sv
// Sequential inverse arithmetic unit: shift-left, shift-add multiply and
// two's-complement to sign-magnitude conversion with registered result/status.
module sync_arith_inv_unit_29
  import sync_arith_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [M-1:0] iarg_A,
  input  logic [M-1:0] iarg_B,
  input  logic [3:0]   iop,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status,
  output logic         o_busy,
  output logic         o_valid
);

  localparam int SW = $clog2(M);

  state_e       state_q, state_d;
  logic [M-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic [M-1:0] res_q, res_d;
  logic [3:0]   stat_q, stat_d;
  logic [M-1:0] result_q, result_d;
  logic [3:0]   status_q, status_d;
  logic         valid_q, valid_d;

  logic           mul_start, mul_done;
  logic [2*M-1:0] product;

  logic [M-1:0]   exec_res;
  logic           exec_ovf, exec_inv;
  logic [2*M-1:0] shl_wide;
  logic [M-2:0]   neg_low;
  logic           b_big;

  assign mul_start = (state_q == S_IDLE) && i_start && (iop == OP_MUL);

  seq_mul_29 #(.M(M)) u_mul (
    .clk     (clk),
    .rst     (i_reset),
    .start   (mul_start),
    .a       (iarg_A),
    .b       (iarg_B),
    .done    (mul_done),
    .product (product)
  );

  // Only the low M-1 bits of -A are needed; the sign bit is forced to 1.
  assign neg_low  = ~a_q[M-2:0] + {{(M-2){1'b0}}, 1'b1};
  assign shl_wide = {{M{1'b0}}, a_q} << b_q[SW-1:0];
  assign b_big    = |b_q[M-1:SW];

  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    exec_inv = 1'b0;
    case (op_q)
      OP_SHL: begin
        if (b_big) begin
          exec_ovf = |a_q;
        end else begin
          exec_res = shl_wide[M-1:0];
          exec_ovf = |shl_wide[2*M-1:M];
        end
      end
      OP_U2ZM: begin
        if (!a_q[M-1]) begin
          exec_res = a_q;
        end else if (a_q[M-2:0] == '0) begin
          exec_ovf = 1'b1;
        end else begin
          exec_res = {1'b1, neg_low};
        end
      end
      default: exec_inv = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    stat_d   = stat_q;
    result_d = result_q;
    status_d = status_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = iarg_A;
          b_d     = iarg_B;
          op_d    = iop;
          state_d = (iop == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = exec_res;
        stat_d  = pack_status(exec_res == '0, exec_res[M-1], exec_ovf, exec_inv);
        state_d = S_WB;
      end
      S_MUL: begin
        if (mul_done) begin
          res_d   = product[M-1:0];
          stat_d  = pack_status(product[M-1:0] == '0, product[M-1],
                                |product[2*M-1:M], 1'b0);
          state_d = S_WB;
        end
      end
      S_WB: begin
        result_d = res_q;
        status_d = stat_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      stat_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      stat_q   <= stat_d;
      result_q <= result_d;
      status_q <= status_d;
      valid_q  <= valid_d;
    end
  end

  assign o_result = result_q;
  assign o_status = status_q;
  assign o_busy   = (state_q != S_IDLE);
  assign o_valid  = valid_q;

endmodule

// File: doc/sync_arith_inv_unit_29.md
# sync_arith_inv_unit_29

Sequential companion to the team's synchronous arithmetic unit, computing the inverse operations: left shift, iterative multiplication and two's-complement (U2) to sign-magnitude (ZM) conversion. It accepts one operation per start pulse, reports busy while working and pulses valid when the registered result and status update. It sits beside the existing arithmetic unit on the same operand/opcode bus.

## Interface
- M, 32, operand/result width (≥ 4, power of two)
- clk  input  1  rising-edge clock
- i_reset  input  1  asynchronous, active-high reset
- i_start  input  1  request; sampled only when o_busy = 0
- iarg_A  input  M  operand A
- iarg_B  input  M  operand B (shift amount or multiplier)
- iop  input  4  opcode: 0000 shift-left, 0001 multiply, 0010 U2→ZM, others invalid
- o_result  output  M  registered result, held until next writeback
- o_status  output  4  [0] zero, [1] negative (o_result MSB), [2] overflow, [3] invalid op
- o_busy  output  1  operation in progress
- o_valid  output  1  one-cycle pulse at writeback

## Operation
- FSM states: IDLE, EXEC, MUL, WB.
- IDLE: when i_start = 1, capture A, B and op at edge N; o_busy rises. Go to MUL for op 0001, otherwise EXEC.
- EXEC: compute the single-cycle result, then go to WB.
- MUL: shift-add over M iterations into a 2M-bit accumulator, using a counter of $clog2(M)+1 bits. After the last iteration, go to WB.
- WB: write o_result and o_status, pulse o_valid, drop o_busy, return to IDLE.
- Shift-left: result = A << B.
  - B ≥ M gives result 0, with overflow = (A ≠ 0).
  - Otherwise overflow = any 1 shifted out.
- Multiply: unsigned. Result = low M bits of A·B; overflow = high M bits ≠ 0.
- U2→ZM:
  - A ≥ 0: result = A.
  - A = 100…0: result 0, overflow 1.
  - Otherwise: result = {1, (−A)[M−2:0]}.
  - Negative zero is never produced.
- Invalid op: result 0, status = invalid | zero.
- Zero flag = (o_result == 0) for all ops.

## Timing
- Reset (asynchronous, any time): state IDLE; o_result = 0, o_status = 0000, o_busy = 0, o_valid = 0.
- Reset mid-operation aborts the operation with no o_valid pulse.
- Start accepted at edge N:
  - o_busy is high from edge N until the writeback edge.
  - Shift, convert and invalid ops: writeback at edge N+2.
  - Multiply: writeback at edge N+M+2 (N+34 for M = 32).
- o_valid is high for exactly the one cycle following the writeback edge. o_busy is low in that same cycle.
- i_start while o_busy = 1 is ignored, not queued. Operand and opcode changes during busy have no effect.
- Back-to-back: a start asserted in the o_valid cycle is accepted at the next edge.
- o_result and o_status change only at writeback or reset.

## Structure
- Package sync_arith_pkg holds:
  - the opcode enum, with values shared with the existing arithmetic unit;
  - status bit index constants;
  - the FSM state enum.
- Sub-module seq_mul_29 holds the shift-add multiplier datapath:
  - parameter M;
  - inputs start, A, B;
  - outputs done, product[2M−1:0].
- The top level holds the FSM, the shifter, the converter and the output registers.

## Test plan
- Shift, A = 0x0000FFFF, B = 4 → o_result 0x000FFFF0, status 0000, o_valid one cycle after edge N+2. A = 0xF0000000, B = 4 → 0x00000000, status 0101.
- Multiply, 100 × 10 → 0x000003E8, status 0000, o_busy high for 34 edges. 0x00010000 × 0x00010000 → 0x00000000, status 0101.
- U2→ZM:
  - 0xFFFFFFFF → 0x80000001, status 0010.
  - 0xFFFFFFF6 → 0x8000000A, status 0010.
  - 0x7FFFFFFF → 0x7FFFFFFF, status 0000.
  - 0x80000000 → 0x00000000, status 0101.
- Invalid op 1111 with any operands → 0x00000000, status 1001, writeback at N+2.
- Start a multiply, then pulse i_start with op 0000 during busy → ignored. Only the multiply result appears, with exactly one o_valid.
- Assert i_reset at cycle 10 of a multiply → all outputs 0 immediately and no o_valid. A new shift started after reset completes normally.
